// File: rtl/mmu_pmp_check_if.sv
// Request/response bus of the PMP check stage: TLB-side request, output-stage packet
// and the PMP CSR write port.
interface mmu_pmp_check_if;
  logic        i_req_valid_1;
  logic        o_req_ready_1;
  logic [50:0] i_req_data_51;
  logic        i_priv_m_1;
  logic        o_out_valid_1;
  logic        i_out_ready_1;
  logic [50:0] o_out_data_51;
  logic        i_csr_we_1;
  logic        i_csr_sel_1;
  logic [2:0]  i_csr_idx_3;
  logic [31:0] i_csr_wdata_32;

  modport slave (
    input  i_req_valid_1, i_req_data_51, i_priv_m_1, i_out_ready_1,
    input  i_csr_we_1, i_csr_sel_1, i_csr_idx_3, i_csr_wdata_32,
    output o_req_ready_1, o_out_valid_1, o_out_data_51
  );

  modport master (
    output i_req_valid_1, i_req_data_51, i_priv_m_1, i_out_ready_1,
    output i_csr_we_1, i_csr_sel_1, i_csr_idx_3, i_csr_wdata_32,
    input  o_req_ready_1, o_out_valid_1, o_out_data_51
  );
endinterface

// File: rtl/mmu_pmp_check.sv
// PMP check stage: two-register valid/ready pipeline that checks paddr against the PMP
// entries and overwrites mcause with an access fault when the access is denied.
module mmu_pmp_check #(
  parameter int NUM_ENTRIES = 8,
  parameter int PADDR_W     = 34
) (
  input logic            clk,
  input logic            rst,
  mmu_pmp_check_if.slave bus
);

  // Handshake: a beat moves when valid & ready are both high at a rising edge; valid never
  // depends on ready, and a stage holding valid data keeps it stable until it is taken.
  logic [7:0]  pmp_cfg  [NUM_ENTRIES];
  logic [31:0] pmp_addr [NUM_ENTRIES];

  logic        s1_v, s1_priv, s2_v, s2_ready;
  logic [50:0] s1_data, s2_data, s1_result;

  assign s2_ready          = !s2_v || bus.i_out_ready_1;
  assign bus.o_req_ready_1 = !s1_v || s2_ready;
  assign bus.o_out_valid_1 = s2_v;
  assign bus.o_out_data_51 = s2_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v    <= 1'b0;
      s1_priv <= 1'b0;
      s1_data <= '0;
      s2_v    <= 1'b0;
      s2_data <= '0;
    end else begin
      if (bus.o_req_ready_1) begin
        s1_v <= bus.i_req_valid_1;
        if (bus.i_req_valid_1) begin
          s1_data <= bus.i_req_data_51;
          s1_priv <= bus.i_priv_m_1;
        end
      end
      if (s2_ready) begin
        s2_v <= s1_v;
        if (s1_v) s2_data <= s1_result;
      end
    end
  end

  // CSR writes: a locked entry, or the lower bound of a locked TOR entry above, is frozen.
  logic [2:0] csr_idx_nxt;
  logic       csr_entry_locked, csr_tor_above_locked;

  assign csr_idx_nxt          = bus.i_csr_idx_3 + 3'd1;
  assign csr_entry_locked     = pmp_cfg[bus.i_csr_idx_3][7];
  assign csr_tor_above_locked = (bus.i_csr_idx_3 != 3'd7) && pmp_cfg[csr_idx_nxt][7]
                                && (pmp_cfg[csr_idx_nxt][4:3] == 2'b01);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        pmp_cfg[i]  <= 8'h00;
        pmp_addr[i] <= 32'h0;
      end
    end else if (bus.i_csr_we_1 && !csr_entry_locked) begin
      if (!bus.i_csr_sel_1)
        pmp_cfg[bus.i_csr_idx_3] <= bus.i_csr_wdata_32[7:0] & 8'h9F;
      else if (!csr_tor_above_locked)
        pmp_addr[bus.i_csr_idx_3] <= bus.i_csr_wdata_32;
    end
  end

  logic [PADDR_W-1:0]     paddr;
  logic [NUM_ENTRIES-1:0] entry_match;

  assign paddr = s1_data[PADDR_W-1:0];

  for (genvar g = 0; g < NUM_ENTRIES; g++) begin : g_entry
    logic [PADDR_W-1:0] lo, hi;
    logic [31:0]        napot_ign;
    logic               m;

    if (g == 0) begin : g_lo0
      assign lo = '0;
    end else begin : g_lo
      assign lo = {pmp_addr[g-1], 2'b00};
    end
    assign hi = {pmp_addr[g], 2'b00};
    // Trailing ones plus the first zero above them are the don't-care bits of a NAPOT region.
    assign napot_ign = pmp_addr[g] ^ (pmp_addr[g] + 32'd1);

    always_comb begin
      m = 1'b0;
      case (pmp_cfg[g][4:3])
        2'b01:   m = (paddr >= lo) && (paddr < hi);
        2'b10:   m = (paddr[PADDR_W-1:2] == pmp_addr[g]);
        2'b11:   m = (((paddr[PADDR_W-1:2] ^ pmp_addr[g]) & ~napot_ign) == 32'd0);
        default: m = 1'b0;
      endcase
    end
    assign entry_match[g] = m;
  end

  logic       hit, grant, is_store;
  logic [7:0] win_cfg;
  logic [4:0] mcause_in;

  assign is_store  = s1_data[34];
  assign mcause_in = s1_data[40:36];

  always_comb begin
    hit     = 1'b0;
    win_cfg = 8'h00;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (entry_match[i]) begin
        hit     = 1'b1;
        win_cfg = pmp_cfg[i];
      end
    end
    if (!hit)                         grant = s1_priv;
    else if (s1_priv && !win_cfg[7])  grant = 1'b1;
    else                              grant = is_store ? win_cfg[1] : win_cfg[0];

    s1_result = s1_data;
    if (mcause_in == 5'd0 && !grant) s1_result[40:36] = is_store ? 5'd7 : 5'd5;
  end

  // Execute permission and the reserved cfg bits have no consumer in this stage.
  logic unused_cfg_bits;
  always_comb begin
    unused_cfg_bits = 1'b0;
    for (int i = 0; i < NUM_ENTRIES; i++)
      unused_cfg_bits = unused_cfg_bits ^ (^{pmp_cfg[i][6:5], pmp_cfg[i][2]});
  end

endmodule

// File: tb/tb_mmu_pmp_check.sv
// Directed bench for mmu_pmp_check: reset state, OFF/TOR/NA4/NAPOT matching, priority,
// locking, page-fault passthrough, mid-flight reset and a stalled back-to-back burst.
module tb_mmu_pmp_check;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mmu_pmp_check_if bus ();

  mmu_pmp_check dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int          total = 0;
  int          bad   = 0;
  logic [50:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [50:0] pk(input logic [3:0] way, input logic [5:0] idx,
                                     input logic [4:0] mc, input logic [1:0] it,
                                     input logic [33:0] pa);
    return {way, idx, mc, it, pa};
  endfunction

  task automatic idle_inputs();
    bus.i_req_valid_1  = 1'b0;
    bus.i_req_data_51  = '0;
    bus.i_priv_m_1     = 1'b0;
    bus.i_out_ready_1  = 1'b1;
    bus.i_csr_we_1     = 1'b0;
    bus.i_csr_sel_1    = 1'b0;
    bus.i_csr_idx_3    = 3'd0;
    bus.i_csr_wdata_32 = 32'h0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic csr_wr(input logic sel, input logic [2:0] idx, input logic [31:0] wd);
    @(negedge clk);
    bus.i_csr_we_1     = 1'b1;
    bus.i_csr_sel_1    = sel;
    bus.i_csr_idx_3    = idx;
    bus.i_csr_wdata_32 = wd;
    @(posedge clk);
    #1 bus.i_csr_we_1 = 1'b0;
  endtask

  // lat counts negedges after the accepting edge before o_out_valid_1 is seen.
  task automatic do_req(input string tag, input logic [50:0] d, input logic priv,
                        input logic [50:0] exp, output int lat);
    int n;
    @(negedge clk);
    bus.i_req_valid_1 = 1'b1;
    bus.i_req_data_51 = d;
    bus.i_priv_m_1    = priv;
    bus.i_out_ready_1 = 1'b1;
    n = 0;
    while (!bus.o_req_ready_1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 bus.i_req_valid_1 = 1'b0;
    lat = 0;
    @(negedge clk);
    while (!bus.o_out_valid_1 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_data"}, bus.o_out_valid_1 ? {13'd0, bus.o_out_data_51} : 64'hDEAD, {13'd0, exp});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    logic [50:0] items [6];
    logic        prv   [6];
    int          sent, got, blocked;

    idle_inputs();
    rst = 1'b1;
    do_reset();

    // Reset state
    chk("rst_out_valid", {63'd0, bus.o_out_valid_1}, 64'd0);
    chk("rst_out_data", {13'd0, bus.o_out_data_51}, 64'd0);
    chk("rst_req_ready", {63'd0, bus.o_req_ready_1}, 64'd1);

    // All entries OFF, U-mode load: load access fault, two edges from presentation to output
    do_req("off_load", pk(4'hA, 6'h15, 5'd0, 2'b00, 34'h1000), 1'b0,
           pk(4'hA, 6'h15, 5'd5, 2'b00, 34'h1000), lat);
    chk("latency", lat, 64'd1);

    // NAPOT entry 0: 0x7FF has 11 trailing ones, so the region is 2^14 bytes at 0
    csr_wr(1'b1, 3'd0, 32'h0000_07FF);
    csr_wr(1'b0, 3'd0, 32'h0000_001B);
    do_req("napot_in", pk(4'h1, 6'h02, 5'd0, 2'b01, 34'h1FFC), 1'b0,
           pk(4'h1, 6'h02, 5'd0, 2'b01, 34'h1FFC), lat);
    do_req("napot_top", pk(4'h2, 6'h03, 5'd0, 2'b01, 34'h3FFC), 1'b0,
           pk(4'h2, 6'h03, 5'd0, 2'b01, 34'h3FFC), lat);
    do_req("napot_out", pk(4'h3, 6'h04, 5'd0, 2'b11, 34'h4000), 1'b0,
           pk(4'h3, 6'h04, 5'd7, 2'b11, 34'h4000), lat);

    // Entry 0 TOR [0,0x4000) R only; entry 1 NA4 at 0x100 with W
    do_reset();
    csr_wr(1'b1, 3'd0, 32'h0000_1000);
    csr_wr(1'b0, 3'd0, 32'h0000_0009);
    csr_wr(1'b1, 3'd1, 32'h0000_0040);
    csr_wr(1'b0, 3'd1, 32'h0000_0012);
    do_req("prio_store", pk(4'h4, 6'h10, 5'd0, 2'b01, 34'h100), 1'b0,
           pk(4'h4, 6'h10, 5'd7, 2'b01, 34'h100), lat);
    do_req("prio_load", pk(4'h5, 6'h11, 5'd0, 2'b00, 34'h100), 1'b0,
           pk(4'h5, 6'h11, 5'd0, 2'b00, 34'h100), lat);
    do_req("tor_last", pk(4'h6, 6'h12, 5'd0, 2'b10, 34'h3FFC), 1'b0,
           pk(4'h6, 6'h12, 5'd0, 2'b10, 34'h3FFC), lat);
    do_req("tor_bound", pk(4'h7, 6'h13, 5'd0, 2'b00, 34'h4000), 1'b0,
           pk(4'h7, 6'h13, 5'd5, 2'b00, 34'h4000), lat);
    do_req("m_unlocked", pk(4'h8, 6'h14, 5'd0, 2'b01, 34'h100), 1'b1,
           pk(4'h8, 6'h14, 5'd0, 2'b01, 34'h100), lat);

    // Page-fault mcause passes through a denying config
    do_reset();
    do_req("pf_pass", pk(4'h9, 6'h3F, 5'd13, 2'b00, 34'h2_0000_0000), 1'b0,
           pk(4'h9, 6'h3F, 5'd13, 2'b00, 34'h2_0000_0000), lat);

    // Reset while a packet sits in S1 drops it
    @(negedge clk);
    bus.i_req_valid_1 = 1'b1;
    bus.i_req_data_51 = pk(4'hF, 6'h01, 5'd0, 2'b00, 34'h10);
    @(posedge clk);
    #1 bus.i_req_valid_1 = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("midrst_drop", {63'd0, bus.o_out_valid_1}, 64'd0);
    end

    // Locked NAPOT entry 0 (R only): addr and cfg writes are ignored, M-mode is enforced
    do_reset();
    csr_wr(1'b1, 3'd0, 32'h0000_07FF);
    csr_wr(1'b0, 3'd0, 32'h0000_0099);
    csr_wr(1'b1, 3'd0, 32'h0000_0000);
    csr_wr(1'b0, 3'd0, 32'h0000_001B);
    do_req("lock_m_store", pk(4'h1, 6'h20, 5'd0, 2'b01, 34'h100), 1'b1,
           pk(4'h1, 6'h20, 5'd7, 2'b01, 34'h100), lat);
    do_req("lock_addr_kept", pk(4'h2, 6'h21, 5'd0, 2'b00, 34'h3FF8), 1'b0,
           pk(4'h2, 6'h21, 5'd0, 2'b00, 34'h3FF8), lat);
    do_req("lock_m_load", pk(4'h3, 6'h22, 5'd0, 2'b00, 34'h100), 1'b1,
           pk(4'h3, 6'h22, 5'd0, 2'b00, 34'h100), lat);
    do_reset();
    csr_wr(1'b1, 3'd0, 32'h0000_07FF);
    csr_wr(1'b0, 3'd0, 32'h0000_0019);
    do_req("nolock_m_store", pk(4'h4, 6'h23, 5'd0, 2'b01, 34'h100), 1'b1,
           pk(4'h4, 6'h23, 5'd0, 2'b01, 34'h100), lat);

    // Locked TOR entry 1 freezes pmpaddr[0], its lower bound
    do_reset();
    csr_wr(1'b1, 3'd0, 32'h0000_0100);
    csr_wr(1'b1, 3'd1, 32'h0000_0200);
    csr_wr(1'b0, 3'd1, 32'h0000_0089);
    do_req("torlock_base", pk(4'h5, 6'h24, 5'd0, 2'b00, 34'h400), 1'b0,
           pk(4'h5, 6'h24, 5'd0, 2'b00, 34'h400), lat);
    csr_wr(1'b1, 3'd0, 32'h0000_0180);
    do_req("torlock_kept", pk(4'h6, 6'h25, 5'd0, 2'b00, 34'h400), 1'b0,
           pk(4'h6, 6'h25, 5'd0, 2'b00, 34'h400), lat);
    do_req("torlock_below", pk(4'h7, 6'h26, 5'd0, 2'b00, 34'h3FC), 1'b0,
           pk(4'h7, 6'h26, 5'd5, 2'b00, 34'h3FC), lat);

    // Back-to-back burst, output stalled for 3 cycles once the packet reaches S2
    do_reset();
    for (int i = 0; i < 6; i++) begin
      items[i] = pk(i[3:0], 6'(i * 3), 5'd0, {1'b0, i[0]}, 34'h2000 + 34'(i * 8));
      prv[i]   = (i % 3 == 0);
    end
    sent = 0;
    got = 0;
    blocked = 0;
    for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
      @(negedge clk);
      bus.i_out_ready_1 = (cyc >= 5);
      if (sent < 6) begin
        bus.i_req_valid_1 = 1'b1;
        bus.i_req_data_51 = items[sent];
        bus.i_priv_m_1    = prv[sent];
      end else begin
        bus.i_req_valid_1 = 1'b0;
      end
      #1;
      if (bus.o_out_valid_1) begin
        chk("burst_q_nonempty", {63'd0, exp_q.size() != 0}, 64'd1);
        if (exp_q.size() != 0) begin
          if (bus.i_out_ready_1) begin
            chk("burst_order", {13'd0, bus.o_out_data_51}, {13'd0, exp_q.pop_front()});
            got++;
          end else begin
            chk("stall_hold", {13'd0, bus.o_out_data_51}, {13'd0, exp_q[0]});
          end
        end
      end
      if (bus.i_req_valid_1 && !bus.o_req_ready_1) blocked++;
      if (bus.i_req_valid_1 && bus.o_req_ready_1) begin
        logic [50:0] e;
        e = items[sent];
        if (!prv[sent]) e[40:36] = e[34] ? 5'd7 : 5'd5;
        exp_q.push_back(e);
        sent++;
      end
    end
    @(negedge clk);
    bus.i_req_valid_1 = 1'b0;
    chk("burst_got", got, 64'd6);
    chk("burst_blocked", blocked, 64'd3);
    chk("burst_q_empty", exp_q.size(), 64'd0);
    repeat (3) begin
      @(negedge clk);
      chk("burst_no_dup", {63'd0, bus.o_out_valid_1}, 64'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
